// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming SECDED encode sequencer and the ALU it drives.
// Holds FSM states, ALU op codes, parity slot positions and packing helpers.
package hamming_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned MSG_H_W = 3;
  localparam int unsigned OP_W    = 4;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_P1   = 4'd1,
    S_P2   = 4'd2,
    S_P4   = 4'd3,
    S_P8   = 4'd4,
    S_PKL  = 4'd5,
    S_PKM  = 4'd6,
    S_P0   = 4'd7,
    S_DONE = 4'd8
  } enc_state_t;

  localparam logic [OP_W-1:0] ALU_NOP = 4'b0000;
  localparam logic [OP_W-1:0] ALU_P0  = 4'b1000;
  localparam logic [OP_W-1:0] ALU_P1  = 4'b1001;
  localparam logic [OP_W-1:0] ALU_P2  = 4'b1010;
  localparam logic [OP_W-1:0] ALU_P4  = 4'b1011;
  localparam logic [OP_W-1:0] ALU_P8  = 4'b1100;
  localparam logic [OP_W-1:0] ALU_PKL = 4'b1101;
  localparam logic [OP_W-1:0] ALU_PKM = 4'b1110;

  // Parity slot positions within the 16-bit codeword
  localparam int unsigned POS_P0 = 0;
  localparam int unsigned POS_P1 = 1;
  localparam int unsigned POS_P2 = 2;
  localparam int unsigned POS_P4 = 4;
  localparam int unsigned POS_P8 = 8;

  // Low-byte parity bits p1/p2/p4 dropped into their slots
  function automatic logic [BYTE_W-1:0] lsw_parity_mask(input logic p1, input logic p2,
                                                        input logic p4);
    return (BYTE_W'(p1) << POS_P1) | (BYTE_W'(p2) << POS_P2) | (BYTE_W'(p4) << POS_P4);
  endfunction

  // High-byte parity bit p8 dropped into its slot
  function automatic logic [BYTE_W-1:0] msw_parity_mask(input logic p8);
    return BYTE_W'(p8) << (POS_P8 - BYTE_W);
  endfunction

endpackage

// File: rtl/hamming_enc_seq.sv
// Sequences the external ALU through parity and packing ops to build a
// Hamming(16,11) SECDED codeword; ALU drive is registered from the next state.
module hamming_enc_seq
  import hamming_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] msg_lsw,
  input  logic [BYTE_W-1:0] msg_msw,
  output logic              busy,
  output logic              done,
  output logic [BYTE_W-1:0] enc_lsw,
  output logic [BYTE_W-1:0] enc_msw,
  output logic [OP_W-1:0]   alu_op,
  output logic [BYTE_W-1:0] alu_a,
  output logic [BYTE_W-1:0] alu_b,
  input  logic [BYTE_W-1:0] alu_rslt
);

  enc_state_t         state;
  logic [BYTE_W-1:0]  m_l;
  logic [MSG_H_W-1:0] m_h;
  logic               p1, p2, p4, p8;
  logic [BYTE_W-1:0]  lsw_r;
  logic [BYTE_W-1:0]  msw_r;
  logic [BYTE_W-1:0]  pk_msw;

  // Upper message bits carry no data
  logic unused_msw;
  assign unused_msw = ^msg_msw[BYTE_W-1:MSG_H_W];

  assign pk_msw = alu_rslt | msw_parity_mask(p8);

  // Each state's capture happens at its closing edge, together with the drive for the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      enc_lsw <= '0;
      enc_msw <= '0;
      alu_op  <= ALU_NOP;
      alu_a   <= '0;
      alu_b   <= '0;
      m_l     <= '0;
      m_h     <= '0;
      p1      <= 1'b0;
      p2      <= 1'b0;
      p4      <= 1'b0;
      p8      <= 1'b0;
      lsw_r   <= '0;
      msw_r   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            m_l    <= msg_lsw;
            m_h    <= msg_msw[MSG_H_W-1:0];
            busy   <= 1'b1;
            state  <= S_P1;
            alu_op <= ALU_P1;
            alu_a  <= msg_lsw;
            alu_b  <= BYTE_W'(msg_msw[MSG_H_W-1:0]);
          end
        end
        S_P1: begin
          p1     <= alu_rslt[0];
          state  <= S_P2;
          alu_op <= ALU_P2;
        end
        S_P2: begin
          p2     <= alu_rslt[0];
          state  <= S_P4;
          alu_op <= ALU_P4;
        end
        S_P4: begin
          p4     <= alu_rslt[0];
          state  <= S_P8;
          alu_op <= ALU_P8;
        end
        S_P8: begin
          p8     <= alu_rslt[0];
          state  <= S_PKL;
          alu_op <= ALU_PKL;
          alu_a  <= m_l;
          alu_b  <= '0;
        end
        S_PKL: begin
          lsw_r  <= alu_rslt | lsw_parity_mask(p1, p2, p4);
          state  <= S_PKM;
          alu_op <= ALU_PKM;
          alu_a  <= m_l;
          alu_b  <= BYTE_W'(m_h);
        end
        S_PKM: begin
          msw_r  <= pk_msw;
          state  <= S_P0;
          alu_op <= ALU_P0;
          alu_a  <= lsw_r;
          alu_b  <= pk_msw;
        end
        S_P0: begin
          lsw_r   <= {lsw_r[BYTE_W-1:1], alu_rslt[0]};
          enc_lsw <= {lsw_r[BYTE_W-1:1], alu_rslt[0]};
          enc_msw <= msw_r;
          done    <= 1'b1;
          state   <= S_DONE;
          alu_op  <= ALU_NOP;
          alu_a   <= '0;
          alu_b   <= '0;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy   <= 1'b0;
          state  <= S_IDLE;
          alu_op <= ALU_NOP;
          alu_a  <= '0;
          alu_b  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_enc_seq.sv
// Bench for hamming_enc_seq: a golden ALU model closes the loop, directed
// vectors plus an exhaustive message sweep checked against a reference encoder.
module tb_hamming_enc_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] msg_lsw, msg_msw;
  logic       busy, done;
  logic [7:0] enc_lsw, enc_msw;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_rslt;

  int total = 0;
  int bad   = 0;
  logic [3:0] op_trace [8];

  always #5 clk = ~clk;

  hamming_enc_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .msg_lsw  (msg_lsw),
    .msg_msw  (msg_msw),
    .busy     (busy),
    .done     (done),
    .enc_lsw  (enc_lsw),
    .enc_msw  (enc_msw),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_rslt (alu_rslt)
  );

  // Golden ALU: data word is {b[2:0], a}
  function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [10:0] d;
    d = {b[2:0], a};
    case (op)
      4'h9: return {7'b0, d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10]};
      4'hA: return {7'b0, d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10]};
      4'hB: return {7'b0, d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10]};
      4'hC: return {7'b0, ^d[10:4]};
      4'hD: return {a[3:1], 1'b0, a[0], 3'b0};
      4'hE: return {b[2:0], a[7:4], 1'b0};
      4'h8: return {7'b0, ^{a, b}};
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_rslt = alu_model(alu_op, alu_a, alu_b);

  // Reference encoder built from position arithmetic
  function automatic logic [15:0] ref_encode(input logic [10:0] d);
    logic [15:0] cw;
    int k;
    cw = '0;
    k = 0;
    for (int i = 1; i < 16; i++) begin
      if ((i & (i - 1)) != 0) begin
        cw[i] = d[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      logic par;
      par = 1'b0;
      for (int i = 1; i < 16; i++) if ((i & p) != 0 && i != p) par ^= cw[i];
      cw[p] = par;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  // Starts an encode from IDLE; returns result, latency and busy cycle count, ends in IDLE
  task automatic run_encode(input logic [7:0] l, input logic [7:0] h,
                            output logic [7:0] el, output logic [7:0] em,
                            output int lat, output int busy_cycles);
    msg_lsw = l;
    msg_msw = h;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cycles = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c <= 7) op_trace[c] = alu_op;
      if (busy) busy_cycles++;
      if (done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    el = enc_lsw;
    em = enc_msw;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    msg_lsw = 8'h00;
    msg_msw = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++; $display("FAIL reset_flags busy/done=%b%b want 00", busy, done);
    end
    total++;
    if ({enc_msw, enc_lsw} !== 16'h0000) begin
      bad++; $display("FAIL reset_enc got %h%h want 0000", enc_msw, enc_lsw);
    end
    total++;
    if ({alu_op, alu_a, alu_b} !== 20'h0) begin
      bad++; $display("FAIL reset_alu op=%h a=%h b=%h want 0", alu_op, alu_a, alu_b);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    logic [7:0] el, em;
    int lat, bc;
    run_encode(8'h00, 8'h00, el, em, lat, bc);
    total++;
    if (lat !== 8) begin bad++; $display("FAIL zero_latency got %0d want 8", lat); end
    total++;
    if (bc !== 8) begin bad++; $display("FAIL zero_busy_cycles got %0d want 8", bc); end
    total++;
    if ({em, el} !== 16'h0000) begin
      bad++; $display("FAIL zero_cw got %h%h want 0000", em, el);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_idle got %b want 0", busy); end
  endtask

  task automatic test_op_sequence();
    logic [7:0] el, em;
    logic [3:0] exp_ops [8];
    int lat, bc;
    exp_ops = '{4'h0, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'h8};
    run_encode(8'h01, 8'h00, el, em, lat, bc);
    for (int c = 1; c <= 7; c++) begin
      total++;
      if (op_trace[c] !== exp_ops[c]) begin
        bad++; $display("FAIL op_seq[%0d] got %h want %h", c, op_trace[c], exp_ops[c]);
      end
    end
    total++;
    if ({em, el} !== 16'h000F) begin
      bad++; $display("FAIL d0_cw got %h%h want 000F", em, el);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] vl [4];
    logic [7:0] vh [4];
    logic [15:0] vexp [4];
    logic [7:0] el, em;
    int lat, bc;
    vl = '{8'hFF, 8'hFF, 8'h10, 8'h00};
    vh = '{8'h07, 8'hFF, 8'h00, 8'h04};
    vexp = '{16'hFFFF, 16'hFFFF, 16'h0303, 16'h8117};
    for (int i = 0; i < 4; i++) begin
      run_encode(vl[i], vh[i], el, em, lat, bc);
      total++;
      if ({em, el} !== vexp[i]) begin
        bad++; $display("FAIL pattern[%0d] got %h%h want %h", i, em, el, vexp[i]);
      end
    end
  endtask

  task automatic test_input_change();
    int dones = 0;
    msg_lsw = 8'hFF;
    msg_msw = 8'h07;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) msg_lsw = 8'h01;
      if (c == 3) start = 1'b1;
      if (c == 4) start = 1'b0;
      if (c == 8) start = 1'b1;
      if (c == 9) start = 1'b0;
      if (done) dones++;
      if (c == 8) begin
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL chg_done_c8 got %b want 1", done); end
      end
      @(posedge clk); #1;
    end
    total++;
    if (dones !== 1) begin bad++; $display("FAIL chg_done_count got %0d want 1", dones); end
    total++;
    if ({enc_msw, enc_lsw} !== 16'hFFFF) begin
      bad++; $display("FAIL chg_cw got %h%h want FFFF", enc_msw, enc_lsw);
    end
    total++;
    if ({busy, alu_op} !== 5'b0) begin
      bad++; $display("FAIL chg_idle busy=%b op=%h want 0/0", busy, alu_op);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] el, em;
    int lat, bc;
    int dones = 0;
    msg_lsw = 8'h01;
    msg_msw = 8'h00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    total++;
    if (alu_op !== 4'hE) begin bad++; $display("FAIL rst_pkm_op got %h want e", alu_op); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if ({busy, done, enc_msw, enc_lsw, alu_op, alu_a, alu_b} !== 38'h0) begin
      bad++; $display("FAIL rst_mid_clear busy=%b done=%b enc=%h%h op=%h a=%h b=%h want 0",
                      busy, done, enc_msw, enc_lsw, alu_op, alu_a, alu_b);
    end
    for (int c = 0; c < 6; c++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL rst_mid_no_done got %0d want 0", dones); end
    run_encode(8'hFF, 8'h07, el, em, lat, bc);
    total++;
    if ({em, el, 8'(lat)} !== 24'hFFFF08) begin
      bad++; $display("FAIL rst_fresh got %h%h lat=%0d want FFFF lat=8", em, el, lat);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] el, em;
    logic [15:0] cw;
    logic [3:0] syn;
    int lat, bc;
    for (int m = 0; m < 2048; m++) begin
      logic [10:0] d;
      d = 11'(m);
      run_encode(d[7:0], {5'($urandom_range(0, 31)), d[10:8]}, el, em, lat, bc);
      cw = {em, el};
      syn = '0;
      for (int i = 1; i < 16; i++) if (cw[i]) syn ^= 4'(i);
      total++;
      if (cw !== ref_encode(d)) begin
        bad++; $display("FAIL sweep_cw msg=%h got %h want %h", d, cw, ref_encode(d));
      end
      total++;
      if (^cw !== 1'b0) begin bad++; $display("FAIL sweep_parity msg=%h got %h odd", d, cw); end
      total++;
      if (syn !== 4'h0 || lat !== 8) begin
        bad++; $display("FAIL sweep_syndrome msg=%h syn=%h lat=%0d want 0/8", d, syn, lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_op_sequence();
    test_patterns();
    test_input_change();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_enc_seq.md
# hamming_enc_seq

Multi-cycle sequencer that encodes an 11-bit message into a 16-bit Hamming SECDED codeword (two bytes, LSW/MSW) by driving the combinational ALU through its parity and packing ops, one op per cycle. Sits directly upstream of the ALU: it owns `ALUOp`, `inA` and `inB` during an encode and consumes `rslt`. Results are registered and presented with a one-cycle `done` pulse.

## Interface
No parameters. Widths are fixed by the 8-bit datapath.

- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request an encode; sampled only in IDLE.
- `msg_lsw` input 8: message bits d7..d0.
- `msg_msw` input 8: bits [2:0] = d10..d8; [7:3] ignored.
- `busy` output 1: high from the cycle after `start` is accepted through the DONE cycle.
- `done` output 1: one-cycle pulse; `enc_lsw`/`enc_msw` are valid from this cycle on.
- `enc_lsw` output 8: codeword bits 7..0.
- `enc_msw` output 8: codeword bits 15..8.
- `alu_op` output 4: drives ALU `ALUOp`.
- `alu_a` output 8: drives ALU `inA`.
- `alu_b` output 8: drives ALU `inB`.
- `alu_rslt` input 8: ALU `rslt`, combinational within the same cycle.

## Operation
- Codeword layout: bit i is Hamming position i.
  - Parity bits: p0 @0, p1 @1, p2 @2, p4 @4, p8 @8.
  - Data bits: d0 @3, d3..d1 @7..5, d10..d4 @15..9.
- On an accepted `start`, latch `msg_lsw` → `m_l` and `msg_msw[2:0]` → `m_h`. Input changes while busy have no effect.
- FSM states: IDLE, P1, P2, P4, P8, PKL, PKM, P0, DONE. Each non-IDLE state lasts exactly one cycle. Order is IDLE→P1→P2→P4→P8→PKL→PKM→P0→DONE→IDLE.
- Per-state ALU drive and what is captured at the end of the cycle:
  - P1: `alu_op=1001`, a=`m_l`, b=`m_h`. Capture p1=`rslt[0]`.
  - P2: `alu_op=1010`. Capture p2.
  - P4: `alu_op=1011`. Capture p4.
  - P8: `alu_op=1100`. Capture p8.
  - PKL: `alu_op=1101`, a=`m_l`. Capture `lsw_r = rslt | {3'b0,p4,1'b0,p2,p1,1'b0}`. The ALU contract is that `rslt = {d3,d2,d1,0,d0,0,0,0}`.
  - PKM: `alu_op=1110`, a=`m_l`, b=`m_h`. Capture `msw_r = rslt | {7'b0,p8}`. The ALU contract is that `rslt = {d10..d4,0}`.
  - P0: `alu_op=1000`, a=`lsw_r`, b=`msw_r`. Capture `lsw_r[0] = rslt[0]`.
  - DONE: `done=1`. Copy `lsw_r`/`msw_r` to `enc_lsw`/`enc_msw`, which are updated coincident with the `done` cycle.
- In IDLE and DONE, `alu_op=0000`, `alu_a=0`, `alu_b=0`.
- `enc_*` hold their value until the next DONE. A new encode does not disturb them before then.
- `start` is ignored while in DONE; back-to-back encodes require `start` to be high in IDLE.
- `rslt` bits other than [0] are ignored in the parity states. `sc_ot`, `ngtv` and `zero` are not used.

## Timing
- Reset values: state=IDLE, `busy=0`, `done=0`, `enc_lsw=0`, `enc_msw=0`, `alu_op=0`, `alu_a=0`, `alu_b=0`, all internal parity/packing registers 0.
- `reset` takes priority at every edge. Asserted mid-encode, it returns to IDLE and clears all state. No `done` is produced for the aborted encode.
- Latency: `start` high in IDLE at edge N → P1 during cycle N+1 → `done` high in cycle N+8 (8 cycles).
- Throughput: one encode per 9 cycles (DONE→IDLE→P1).
- ALU outputs are registered (state-decoded from registered state). The ALU path is combinational, so `alu_rslt` is captured at the same edge that ends the state.

## Structure
- Shared package `hamming_pkg`:
  - `typedef enum logic[3:0] enc_state_t`.
  - Localparams for the ALU op codes used: `ALU_NOP=0000`, `ALU_P0=1000`, `ALU_P1=1001`, `ALU_P2=1010`, `ALU_P4=1011`, `ALU_P8=1100`, `ALU_PKL=1101`, `ALU_PKM=1110`.
  - Bit-position localparams for the parity slots.
  - The ALU also imports this package.
- No sub-module. The ALU is instantiated alongside this block by the parent, not inside it.

## Test plan
The bench pairs the block with a golden ALU model.
- Reset, then `start` with `msg_lsw=0x00`, `msg_msw=0x00` → `done` at cycle N+8, `enc_lsw=0x00`, `enc_msw=0x00`; `busy` high for cycles N+1..N+8.
- `msg_lsw=0x01`, `msg_msw=0x00` → `alu_op` sequence 9,A,B,C,D,E,8, then `enc_lsw=0x0F`, `enc_msw=0x00`.
- `msg_lsw=0xFF`, `msg_msw=0x07` → `enc_lsw=0xFF`, `enc_msw=0xFF`. Also check that `msg_msw[7:3]=11111` does not change the result.
- Change `msg_lsw` from 0xFF to 0x01 during P2; pulse `start` during P4 and during DONE → result is still 0xFF/0xFF, exactly one `done`, and the FSM returns to IDLE.
- Assert `reset` during PKM → next cycle IDLE, all outputs 0, no `done`. A fresh `start` then encodes normally.
- Random 2048-message sweep → every codeword has even overall parity, and its syndrome is 0 against a reference Hamming(16,11) encoder.
